fifo_ctrl: RTL and testbench

Pointer and flow-control engine that drives the vector unit's FIFO storage array. It converts a valid/ready push interface and a valid/ready pop interface into write-enable, write-address and read-address strobes for the storage array. It returns the array's combinational read word as pop data. It also tracks occupancy, full/empty and almost-full for the vector unit's issue and writeback queues.

---
 rtl/fifo_ctrl.sv | 87 ++++++++
 tb/tb_fifo_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy engine for an external SIZE-entry storage array; zero-latency head read, write visible next cycle.
// Backpressure: in_ready_o/out_valid_o decode the registered count only; flush and reset clear control state.
module fifo_ctrl #(
  parameter int SIZE        = 10,
  parameter int WIDTH       = 10,
  parameter int ALMOST_FULL = 8,
  localparam int AW         = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int CW         = $clog2(SIZE + 1)
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             mem_w_en_o,
  output logic [AW-1:0]    mem_w_addr_o,
  output logic [WIDTH-1:0] mem_w_data_o,
  output logic [AW-1:0]    mem_r_addr_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o
);

  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [AW-1:0] rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;

  // Explicit wrap compare so non-power-of-2 depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(SIZE - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o        = (count == CW'(SIZE));
  assign empty_o       = (count == '0);
  assign almost_full_o = (count >= CW'(ALMOST_FULL));
  assign count_o       = count;
  assign in_ready_o    = !full_o;
  assign out_valid_o   = !empty_o;

  assign push = in_valid_i & in_ready_o & !flush_i;
  assign pop  = out_valid_o & out_ready_i & !flush_i;

  assign mem_w_en_o   = push;
  assign mem_w_addr_o = wr_ptr;
  assign mem_w_data_o = in_data_i;
  assign mem_r_addr_o = rd_ptr;
  assign out_data_o   = mem_rdata_i;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush_i) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (pop)  rd_ptr_nxt = ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed vector bench for fifo_ctrl (SIZE=10) plus a short SIZE=1 sequence; storage arrays are modelled here.
module tb_fifo_ctrl;

  logic       clk_i = 1'b0;
  logic       rst;
  logic       flush_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [9:0] in_data_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [9:0] out_data_o;
  logic       mem_w_en_o;
  logic [3:0] mem_w_addr_o;
  logic [9:0] mem_w_data_o;
  logic [3:0] mem_r_addr_o;
  logic [9:0] mem_rdata_i;
  logic [3:0] count_o;
  logic       full_o, empty_o, almost_full_o;

  // SIZE=1 instance
  logic       s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [9:0] s_in_data, s_out_data, s_w_data, s_rdata;
  logic       s_w_en, s_full, s_empty, s_af;
  logic [0:0] s_w_addr, s_r_addr, s_count;

  always #5 clk_i = ~clk_i;

  fifo_ctrl #(.SIZE(10), .WIDTH(10), .ALMOST_FULL(8)) u_dut (
    .clk_i(clk_i), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .mem_w_en_o(mem_w_en_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o),
    .mem_r_addr_o(mem_r_addr_o), .mem_rdata_i(mem_rdata_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o)
  );

  fifo_ctrl #(.SIZE(1), .WIDTH(10), .ALMOST_FULL(1)) u_dut1 (
    .clk_i(clk_i), .rst(rst), .flush_i(s_flush),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_data_i(s_in_data),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .out_data_o(s_out_data),
    .mem_w_en_o(s_w_en), .mem_w_addr_o(s_w_addr), .mem_w_data_o(s_w_data),
    .mem_r_addr_o(s_r_addr), .mem_rdata_i(s_rdata),
    .count_o(s_count), .full_o(s_full), .empty_o(s_empty), .almost_full_o(s_af)
  );

  // Storage array models with combinational read
  logic [9:0] mem [10];
  logic [9:0] mem1;
  initial begin
    for (int i = 0; i < 10; i++) mem[i] = '0;
    mem1 = '0;
  end
  always @(posedge clk_i) begin
    if (mem_w_en_o && mem_w_addr_o < 4'd10) mem[mem_w_addr_o] <= mem_w_data_o;
    if (s_w_en) mem1 <= s_w_data;
  end
  assign mem_rdata_i = (mem_r_addr_o < 4'd10) ? mem[mem_r_addr_o] : 10'h3FF;
  assign s_rdata     = mem1;

  typedef struct {
    logic       rst, flush, iv, ordy;
    logic [9:0] din;
    logic [3:0] cnt;
    logic       wen;
    logic [3:0] wa, ra;
    logic [9:0] dout;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input logic r, input logic f, input logic iv, input logic [9:0] din,
                              input logic ordy, input int cnt, input logic wen, input int wa,
                              input int ra, input logic [9:0] dout);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.din = din; v.ordy = ordy;
    v.cnt = 4'(cnt); v.wen = wen; v.wa = 4'(wa); v.ra = 4'(ra); v.dout = dout;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;

    // 1: idle after reset
    add(0, 0, 0, 10'h000, 0, 0, 0, 0, 0, 10'h000);
    // 2: fill with 0x001..0x00A
    for (int i = 0; i < 10; i++) add(0, 0, 1, 10'(i + 1), 0, i, 1, i, 0, 10'h001);
    add(0, 0, 1, 10'h0BB, 0, 10, 0, 0, 0, 10'h001);
    // 3: pop 3 from full with in_valid held; pushes wrap to 0,1,2
    add(0, 0, 1, 10'h0AA, 1, 10, 0, 0, 0, 10'h001);
    add(0, 0, 1, 10'h00B, 1, 9, 1, 0, 1, 10'h002);
    add(0, 0, 1, 10'h00C, 1, 9, 1, 1, 2, 10'h003);
    add(0, 0, 1, 10'h00D, 0, 9, 1, 2, 3, 10'h004);
    // drain to count 5: heads 4..8
    for (int k = 0; k < 5; k++) add(0, 0, 0, 10'h000, 1, 10 - k, 0, 3, 3 + k, 10'(4 + k));
    // 4: 20 cycles of simultaneous push/pop at count 5
    for (int m = 0; m < 20; m++)
      add(0, 0, 1, 10'(10'h100 + m), 1, 5, 1, (3 + m) % 10, (8 + m) % 10,
          (m < 5) ? 10'(9 + m) : 10'(10'h100 + m - 5));
    add(0, 0, 1, 10'h114, 0, 5, 1, 3, 8, 10'h10F);
    // 6a: flush at count 6 with push and pop requested
    add(0, 1, 1, 10'h0EE, 1, 6, 0, 4, 8, 10'h10F);
    add(0, 0, 0, 10'h000, 0, 0, 0, 0, 0, 10'h000);
    // 5: push into empty while out_ready held
    add(0, 0, 1, 10'h055, 1, 0, 1, 0, 0, 10'h000);
    add(0, 0, 0, 10'h000, 1, 1, 0, 1, 0, 10'h055);
    add(0, 0, 0, 10'h000, 1, 0, 0, 1, 1, 10'h000);
    // 6b: reset at count 4 with handshakes in flight
    for (int i = 0; i < 4; i++) add(0, 0, 1, 10'(10'h061 + i), 0, i, 1, 1 + i, 1, 10'h061);
    add(1, 0, 1, 10'h0EE, 1, 4, 1, 5, 1, 10'h061);
    add(0, 0, 0, 10'h000, 0, 0, 0, 0, 0, 10'h000);

    repeat (2) @(posedge clk_i);

    foreach (vecs[i]) begin
      @(negedge clk_i);
      rst = vecs[i].rst; flush_i = vecs[i].flush; in_valid_i = vecs[i].iv;
      in_data_i = vecs[i].din; out_ready_i = vecs[i].ordy;
      #1;
      chk("count",       i, 32'(count_o),       32'(vecs[i].cnt));
      chk("full",        i, 32'(full_o),        32'(vecs[i].cnt == 4'd10));
      chk("empty",       i, 32'(empty_o),       32'(vecs[i].cnt == 4'd0));
      chk("almost_full", i, 32'(almost_full_o), 32'(vecs[i].cnt >= 4'd8));
      chk("in_ready",    i, 32'(in_ready_o),    32'(vecs[i].cnt != 4'd10));
      chk("out_valid",   i, 32'(out_valid_o),   32'(vecs[i].cnt != 4'd0));
      chk("w_en",        i, 32'(mem_w_en_o),    32'(vecs[i].wen));
      chk("w_addr",      i, 32'(mem_w_addr_o),  32'(vecs[i].wa));
      chk("r_addr",      i, 32'(mem_r_addr_o),  32'(vecs[i].ra));
      chk("w_data",      i, 32'(mem_w_data_o),  32'(vecs[i].din));
      if (vecs[i].cnt != 4'd0) chk("out_data", i, 32'(out_data_o), 32'(vecs[i].dout));
    end

    // SIZE=1: alternates full/empty, pointers stay at 0
    @(negedge clk_i);
    rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    s_in_valid = 1'b1; s_in_data = 10'h3AA; s_out_ready = 1'b0;
    #1;
    chk("s1_empty_push_wen", 0, 32'(s_w_en), 32'd1);
    chk("s1_empty_ovalid",   0, 32'(s_out_valid), 32'd0);
    @(negedge clk_i);
    s_in_valid = 1'b1; s_in_data = 10'h155; s_out_ready = 1'b1;
    #1;
    chk("s1_full",      1, 32'(s_full), 32'd1);
    chk("s1_af",        1, 32'(s_af), 32'd1);
    chk("s1_count",     1, 32'(s_count), 32'd1);
    chk("s1_in_ready",  1, 32'(s_in_ready), 32'd0);
    chk("s1_wen_full",  1, 32'(s_w_en), 32'd0);
    chk("s1_out_data",  1, 32'(s_out_data), 32'h3AA);
    chk("s1_addrs",     1, 32'({s_w_addr, s_r_addr}), 32'd0);
    @(negedge clk_i);
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    #1;
    chk("s1_empty_again", 2, 32'(s_empty), 32'd1);
    chk("s1_addrs_wrap",  2, 32'({s_w_addr, s_r_addr}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
